// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared ALU operation encodings, sequencer state encoding and a
//             small helper used by the bit-serial ALU and the ALU control
//             decoder.
//  Ports    : (package - none)
//  Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // 3-bit ALU operation codes. Bit 2 doubles as "invert B and seed carry".
    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_RSVD = 3'b011;
    localparam logic [2:0] ALU_ANDN = 3'b100;
    localparam logic [2:0] ALU_ORN  = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // True for operations whose carry/overflow flags are meaningful.
    function automatic logic is_arith(input logic [2:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_SLT);
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/one_bit_alu.sv
`default_nettype none
// ============================================================================
//  Module   : one_bit_alu
//  Purpose  : Single-bit ALU slice. aluop[2] inverts B; aluop[1:0] selects
//             AND / OR / SUM / LESS.
//  Ports    : a_i, b_i    - operand bits
//             cin_i       - carry in
//             less_i      - value passed through for the LESS selection
//             aluop_i     - 3-bit operation code
//             result_o    - selected result bit
//             cout_o      - full-adder carry out
//  Revision : 1.0 - initial release
// ============================================================================
module one_bit_alu (
    input  logic       a_i,
    input  logic       b_i,
    input  logic       cin_i,
    input  logic       less_i,
    input  logic [2:0] aluop_i,
    output logic       result_o,
    output logic       cout_o
);

    logic bb;
    logic sum;

    assign bb     = b_i ^ aluop_i[2];
    assign sum    = a_i ^ bb ^ cin_i;
    assign cout_o = (a_i & bb) | (a_i & cin_i) | (bb & cin_i);

    always_comb begin
        result_o = 1'b0;
        case (aluop_i[1:0])
            2'b00:   result_o = a_i & bb;
            2'b01:   result_o = a_i | bb;
            2'b10:   result_o = sum;
            default: result_o = less_i;
        endcase
    end

endmodule : one_bit_alu
`default_nettype wire

// File: rtl/bit_serial_alu.sv
`default_nettype none
// ============================================================================
//  Module   : bit_serial_alu
//  Purpose  : Multi-cycle sequencer around a single one_bit_alu slice.
//             Processes one operand bit per clock, LSB first, and commits a
//             WIDTH-bit result plus zero/carry/overflow flags.
//  Ports    : clk, rst_n           - clock, async active-low reset
//             start                - request, sampled only in IDLE
//             a, b, aluop          - operands/op, captured on acceptance
//             busy                 - high in RUN and DONE
//             done                 - one-cycle completion pulse
//             result, zero         - registered result and zero flag
//             carry_out, overflow  - arithmetic flags (0 for logic ops)
//  Revision : 1.0 - initial release
// ============================================================================
module bit_serial_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       aluop,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry_out,
    output logic             overflow
);

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_e            state_q,  state_d;
    logic [WIDTH-1:0]  a_sh_q,   a_sh_d;
    logic [WIDTH-1:0]  b_sh_q,   b_sh_d;
    // Holds the WIDTH-1 already-computed bits; the current slice bit is
    // appended on the fly, so the full word is available on the last edge.
    logic [WIDTH-2:0]  res_sh_q, res_sh_d;
    logic [2:0]        op_q,     op_d;
    logic              carry_q,  carry_d;
    logic [CW-1:0]     cnt_q,    cnt_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              zero_q,   zero_d;
    logic              cout_q,   cout_d;
    logic              ovf_q,    ovf_d;

    logic [2:0]        slice_op;
    logic              slice_res;
    logic              slice_cout;
    logic [WIDTH-1:0]  full_res;
    logic              ovf_bit;
    logic              sum_msb;

    // SLT runs the slice as a subtract; the less-than bit is formed at commit.
    assign slice_op = (op_q == ALU_SLT) ? ALU_SUB : op_q;

    one_bit_alu u_slice (
        .a_i      (a_sh_q[0]),
        .b_i      (b_sh_q[0]),
        .cin_i    (carry_q),
        .less_i   (1'b0),
        .aluop_i  (slice_op),
        .result_o (slice_res),
        .cout_o   (slice_cout)
    );

    assign full_res = {slice_res, res_sh_q};
    // Only meaningful on the MSB edge: carry into vs. out of the sign bit.
    assign ovf_bit  = carry_q ^ slice_cout;
    assign sum_msb  = a_sh_q[0] ^ b_sh_q[0] ^ op_q[2] ^ carry_q;

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        op_d     = op_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    op_d    = aluop;
                    carry_d = aluop[2];
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                res_sh_d = full_res[WIDTH-1:1];
                carry_d  = slice_cout;
                if (cnt_q == LAST_BIT) begin
                    // Counter is left at WIDTH-1 rather than wrapping.
                    state_d = ST_DONE;
                    case (op_q)
                        ALU_ADD, ALU_SUB: begin
                            result_d = full_res;
                            cout_d   = slice_cout;
                            ovf_d    = ovf_bit;
                        end
                        ALU_SLT: begin
                            // Sign of the difference, corrected for overflow.
                            result_d = {{(WIDTH-1){1'b0}}, sum_msb ^ ovf_bit};
                            cout_d   = slice_cout;
                            ovf_d    = ovf_bit;
                        end
                        ALU_AND, ALU_OR, ALU_ANDN, ALU_ORN: begin
                            result_d = full_res;
                            cout_d   = 1'b0;
                            ovf_d    = 1'b0;
                        end
                        default: begin
                            result_d = '0;
                            cout_d   = 1'b0;
                            ovf_d    = 1'b0;
                        end
                    endcase
                    zero_d = (result_d == '0);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            op_q     <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            op_q     <= op_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;

endmodule : bit_serial_alu
`default_nettype wire

// File: tb/tb_bit_serial_alu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bit_serial_alu
//  Purpose  : Scoreboard bench for bit_serial_alu: directed and random
//             operations against an arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bit_serial_alu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [2:0]   aluop = '0;
    logic         busy, done, zero, carry_out, overflow;
    logic [W-1:0] result;

    bit_serial_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .aluop     (aluop),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .zero      (zero),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] r;
        logic         z;
        logic         c;
        logic         v;
    } exp_t;

    exp_t sb[$];
    int   errors   = 0;
    int   checks   = 0;
    int   done_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain wide arithmetic on the whole operands.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] op);
        exp_t       e;
        logic [W:0] s;
        e = '0;
        case (op)
            3'b000: e.r = x & y;
            3'b001: e.r = x | y;
            3'b100: e.r = x & ~y;
            3'b101: e.r = x | ~y;
            3'b010: begin
                s   = {1'b0, x} + {1'b0, y};
                e.r = s[W-1:0];
                e.c = s[W];
                e.v = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
            end
            3'b110, 3'b111: begin
                s   = {1'b0, x} + {1'b0, ~y} + 1;
                e.c = s[W];
                e.v = (x[W-1] != y[W-1]) && (s[W-1] != x[W-1]);
                if (op == 3'b110) e.r = s[W-1:0];
                else              e.r = ($signed(x) < $signed(y)) ? 1 : 0;
            end
            default: e.r = '0;
        endcase
        e.z = (e.r == '0);
        return e;
    endfunction

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending op");
            end else begin
                e = sb.pop_front();
                check("result",    result,    e.r);
                check("zero",      zero,      e.z);
                check("carry_out", carry_out, e.c);
                check("overflow",  overflow,  e.v);
            end
        end
    end

    // Called at a negedge; returns at a negedge once the sequencer is idle.
    task automatic wait_idle();
        int k = 0;
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (busy) check("idle_timeout", 1, 0);
    endtask

    // Issue one op, scramble inputs during RUN and check the latency.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] op);
        int lat = 0;
        wait_idle();
        a = x; b = y; aluop = op; start = 1'b1;
        sb.push_back(model(x, y, op));
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; b = $urandom; aluop = 3'($urandom);
        while (!done && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, W);
        @(negedge clk);
    endtask

    initial begin
        int d0;
        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_zero", zero, 1);
        check("rst_carry", carry_out, 0);
        check("rst_ovf", overflow, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset in the middle of an ADD.
        a = 32'h1234_5678; b = 32'h1111_1111; aluop = 3'b010; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_result", result, 0);
        check("mid_rst_zero", zero, 1);
        check("mid_rst_carry", carry_out, 0);
        check("mid_rst_ovf", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases.
        issue(32'h1234_5678, 32'h1111_1111, 3'b010);
        issue(32'h7FFF_FFFF, 32'h0000_0001, 3'b010);
        issue(32'h0000_0005, 32'h0000_0005, 3'b110);
        issue(32'hFFFF_FFFE, 32'h0000_0003, 3'b111);
        issue(32'h8000_0000, 32'h0000_0001, 3'b111);
        issue(32'h0000_0003, 32'hFFFF_FFFE, 3'b111);
        issue(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b000);
        issue(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b001);
        issue(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b100);
        issue(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b101);
        issue(32'hFFFF_FFFF, 32'h0000_0001, 3'b010);
        issue(32'hDEAD_BEEF, 32'h1234_5678, 3'b011);
        issue(32'h0000_0000, 32'h0000_0001, 3'b110);

        // Start held high: accepted only when idle, new operands every cycle.
        wait_idle();
        d0 = done_cnt;
        start = 1'b1;
        for (int i = 0; i < 3 * (W + 2); i++) begin
            if (!busy) sb.push_back(model(a, b, aluop));
            @(posedge clk); #1;
            a = $urandom; b = $urandom; aluop = 3'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);
        check("held_start_dones", done_cnt - d0, 3);

        // Random operations with occasional boundary operands.
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] x, y;
            x = $urandom;
            y = $urandom;
            if ($urandom_range(0, 3) == 0) x = (i % 2 == 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
            if ($urandom_range(0, 3) == 0) y = (i % 3 == 0) ? 32'h7FFF_FFFF : x;
            issue(x, y, 3'($urandom));
        end

        wait_idle();
        repeat (2) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_bit_serial_alu
`default_nettype wire

// File: doc/bit_serial_alu.md
Name: bit_serial_alu

Overview:
- Multi-cycle ALU sequencer that sits directly around the existing 1-bit ALU slice and drives a single instance of it.
- Each cycle it feeds the slice one operand bit pair and a registered carry, then collects the result bit and carry-out.
- Produces a WIDTH-bit result with zero, carry and overflow flags under a start/done handshake.
- Used in the area-reduced datapath variant in place of the ripple array of slices.

Parameters:
- WIDTH, 32, operand/result width in bits (minimum 2).
- CW, $clog2(WIDTH), bit-counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  operand A, captured when start is accepted.
- b  in  WIDTH  operand B, captured when start is accepted.
- aluop  in  3  operation code, captured when start is accepted. Encodings: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 100 AND-NOT-B, 101 OR-NOT-B, 011 reserved (result 0).
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse; result and flags are valid in that cycle.
- result  out  WIDTH  registered result; held until the next accepted start.
- zero  out  1  result == 0; registered with result.
- carry_out  out  1  final carry for ADD/SUB/SLT; 0 for logic ops.
- overflow  out  1  signed overflow for ADD/SUB/SLT; 0 for logic ops.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; busy = done = 0.
  - result = 0, zero = 1, carry_out = overflow = 0.
  - Shift registers, carry and counter are cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start = 1: latch a into a_sh, b into b_sh, aluop into op_r; carry_r = aluop[2]; cnt = 0; go to RUN.
  - For SLT, the slice op is forced to 110 internally.
- RUN, one bit per clock, LSB first:
  - Slice inputs: a = a_sh[0], b = b_sh[0], cin = carry_r, less = 0, aluop = slice_op.
  - Each edge: a_sh and b_sh shift right; slice out shifts into res_sh from the MSB end; carry_r <= cout; cnt++.
  - On the edge where cnt == WIDTH-1:
    - Capture cin_msb = carry_r before update.
    - Capture sum_msb = a_sh[0] ^ b_sh[0] ^ aluop[2] ^ carry_r.
    - Go to DONE.
- On the DONE transition edge, commit the outputs:
  - ADD/SUB: result = final res_sh; carry_out = cout; overflow = cin_msb ^ cout.
  - SLT: result = {WIDTH-1 zeros, sum_msb ^ (cin_msb ^ cout)}; carry_out and overflow as for SUB.
  - Logic ops: result = res_sh; carry_out = overflow = 0.
  - Reserved op: result = 0; flags 0.
  - zero = (committed result == 0).
- DONE: done = 1 for exactly one cycle, then return to IDLE.
  - start in the DONE cycle is ignored; a new start is accepted no earlier than the following IDLE cycle.
- Latency: start accepted at edge 0 → done high in the cycle after edge WIDTH. Throughput is one op per WIDTH+2 cycles.
- start while busy = 1 is ignored; operand inputs may change freely after acceptance.
- Reset asserted mid-RUN aborts immediately to reset values; no partial result is ever visible.
- Wrap-around: ADD 0xFFFFFFFF + 1 gives 0 with carry_out = 1; counter never exceeds WIDTH-1.

Decomposition:
- Shared package (alu_pkg): 3-bit aluop encodings (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT) and state encodings.
- The same aluop constants are used by the ALU control decoder.
- Exactly one sub-module, one_bit_alu, instantiated once; no other hierarchy.

Test Plan:
- Reset mid-RUN: rst_n low after 5 bits of ADD → all outputs at reset values; next start completes normally.
- ADD, WIDTH=32: a=0x7FFFFFFF, b=1, start → done at cycle 33; result=0x80000000, carry_out=0, overflow=1, zero=0.
- SUB: a=5, b=5 → result=0, zero=1, carry_out=1, overflow=0.
- SLT: a=0xFFFFFFFE (−2), b=3 → result=1. SLT with a=0x80000000, b=1 → result=1 (overflow case corrected). SLT with a=3, b=−2 → result=0.
- Logic ops: AND 0xF0F0F0F0, 0xFF00FF00 → 0xF000F000; OR → 0xFFF0FFF0; carry_out = overflow = 0.
- Handshake: start held high continuously → accepted only in IDLE, exactly one done pulse per WIDTH+2 cycles. Operands changed during RUN → no effect on result.
